// File: rtl/cdi_bus_ctrl.sv
// CD-i external bus controller: decodes scc68070 bus cycles onto RAM / ROM / slave-I/O target ports.
// Optional hung-access timeout is compiled in when CDI_BUS_TIMEOUT_EN is defined.
module cdi_bus_ctrl #(
    parameter int ROM_WAIT = 2,
    parameter int IO_WAIT  = 4
`ifdef CDI_BUS_TIMEOUT_EN
    ,
    parameter int TIMEOUT  = 1023
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        as,
    input  logic        lds,
    input  logic        uds,
    input  logic        write_strobe,
    input  logic [23:1] addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        bus_ack,
    output logic        bus_err,
    output logic        mem_req,
    output logic [1:0]  mem_sel,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [23:1] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_WAIT_ACK    = 3'd1;
    localparam logic [2:0] ST_WAIT_STATES = 3'd2;
    localparam logic [2:0] ST_DONE        = 3'd3;
    localparam logic [2:0] ST_ERR         = 3'd4;
    localparam logic [2:0] ST_RECOVER     = 3'd5;

    // Region table indexed by mem_sel: 0 = RAM, 1 = ROM, 2 = slave-I/O (byte-address match).
    localparam int NUM_REGIONS = 3;
    localparam logic [NUM_REGIONS-1:0][23:0] REGION_MASK = {24'hF00000, 24'hF80000, 24'hF00000};
    localparam logic [NUM_REGIONS-1:0][23:0] REGION_BASE = {24'h300000, 24'h180000, 24'h000000};
    localparam logic [NUM_REGIONS-1:0][3:0]  REGION_WAIT = {4'(IO_WAIT), 4'(ROM_WAIT), 4'd0};

`ifdef CDI_BUS_TIMEOUT_EN
    localparam logic [10:0] TIMEOUT_LAST = 11'(TIMEOUT - 1);
`endif

    logic [2:0]  state_reg,     state_next;
    logic        mem_req_reg,   mem_req_next;
    logic [1:0]  mem_sel_reg,   mem_sel_next;
    logic        mem_we_reg,    mem_we_next;
    logic [1:0]  mem_be_reg,    mem_be_next;
    logic [23:1] mem_addr_reg,  mem_addr_next;
    logic [15:0] mem_wdata_reg, mem_wdata_next;
    logic [15:0] cpu_rdata_reg, cpu_rdata_next;
    logic        bus_ack_reg,   bus_ack_next;
    logic        bus_err_reg,   bus_err_next;
    logic [3:0]  wait_cnt_reg,  wait_cnt_next;
`ifdef CDI_BUS_TIMEOUT_EN
    logic [10:0] to_cnt_reg,    to_cnt_next;
`endif

    logic [23:0]            byte_addr;
    logic [NUM_REGIONS-1:0] region_hit;
    logic [1:0]             hit_sel;
    logic                   addr_mapped;
    logic [3:0]             sel_wait;
    logic                   cycle_start;

    assign byte_addr   = {addr, 1'b0};
    assign cycle_start = as && (lds || uds);
    assign addr_mapped = |region_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
            assign region_hit[gi] = ((byte_addr & REGION_MASK[gi]) == REGION_BASE[gi]);
        end
    endgenerate

    always_comb begin
        hit_sel = 2'd0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (region_hit[i]) begin
                hit_sel = 2'(i);
            end
        end
    end

    // Wait count follows the latched target, not the live address bus.
    always_comb begin
        sel_wait = REGION_WAIT[0];
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (mem_sel_reg == 2'(i)) begin
                sel_wait = REGION_WAIT[i];
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        mem_req_next   = mem_req_reg;
        mem_sel_next   = mem_sel_reg;
        mem_we_next    = mem_we_reg;
        mem_be_next    = mem_be_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        cpu_rdata_next = cpu_rdata_reg;
        bus_ack_next   = 1'b0;
        bus_err_next   = 1'b0;
        wait_cnt_next  = wait_cnt_reg;
`ifdef CDI_BUS_TIMEOUT_EN
        to_cnt_next    = to_cnt_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (cycle_start) begin
                    if (addr_mapped) begin
                        mem_sel_next   = hit_sel;
                        mem_we_next    = write_strobe;
                        mem_be_next    = {uds, lds};
                        mem_addr_next  = addr;
                        mem_wdata_next = cpu_wdata;
                        mem_req_next   = 1'b1;
                        state_next     = ST_WAIT_ACK;
`ifdef CDI_BUS_TIMEOUT_EN
                        to_cnt_next    = 11'd0;
`endif
                    end else begin
                        state_next = ST_ERR;
                    end
                end
            end

            ST_WAIT_ACK: begin
                if (mem_ack) begin
                    if (!mem_we_reg) begin
                        cpu_rdata_next = mem_rdata;
                    end
                    mem_req_next  = 1'b0;
                    wait_cnt_next = sel_wait;
                    if (sel_wait == 4'd0) begin
                        state_next   = ST_DONE;
                        bus_ack_next = 1'b1;
                    end else begin
                        state_next = ST_WAIT_STATES;
                    end
                end
`ifdef CDI_BUS_TIMEOUT_EN
                // An ack in the final counted cycle takes priority over the timeout.
                else if (to_cnt_reg == TIMEOUT_LAST) begin
                    mem_req_next = 1'b0;
                    state_next   = ST_ERR;
                end else begin
                    to_cnt_next = to_cnt_reg + 11'd1;
                end
`endif
            end

            ST_WAIT_STATES: begin
                // Leaving as the count steps down to 1 puts bus_ack ROM_WAIT/IO_WAIT cycles after the ack.
                wait_cnt_next = wait_cnt_reg - 4'd1;
                if (wait_cnt_reg <= 4'd2) begin
                    state_next   = ST_DONE;
                    bus_ack_next = 1'b1;
                end
            end

            ST_DONE: begin
                state_next = ST_RECOVER;
            end

            ST_ERR: begin
                bus_err_next = 1'b1;
                state_next   = ST_RECOVER;
            end

            ST_RECOVER: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            mem_req_reg   <= 1'b0;
            mem_sel_reg   <= 2'd0;
            mem_we_reg    <= 1'b0;
            mem_be_reg    <= 2'd0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= 16'd0;
            cpu_rdata_reg <= 16'd0;
            bus_ack_reg   <= 1'b0;
            bus_err_reg   <= 1'b0;
            wait_cnt_reg  <= 4'd0;
`ifdef CDI_BUS_TIMEOUT_EN
            to_cnt_reg    <= 11'd0;
`endif
        end else begin
            state_reg     <= state_next;
            mem_req_reg   <= mem_req_next;
            mem_sel_reg   <= mem_sel_next;
            mem_we_reg    <= mem_we_next;
            mem_be_reg    <= mem_be_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            cpu_rdata_reg <= cpu_rdata_next;
            bus_ack_reg   <= bus_ack_next;
            bus_err_reg   <= bus_err_next;
            wait_cnt_reg  <= wait_cnt_next;
`ifdef CDI_BUS_TIMEOUT_EN
            to_cnt_reg    <= to_cnt_next;
`endif
        end
    end

    assign cpu_rdata = cpu_rdata_reg;
    assign bus_ack   = bus_ack_reg;
    assign bus_err   = bus_err_reg;
    assign mem_req   = mem_req_reg;
    assign mem_sel   = mem_sel_reg;
    assign mem_we    = mem_we_reg;
    assign mem_be    = mem_be_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_cdi_bus_ctrl.sv
// Scoreboard bench for cdi_bus_ctrl: random CPU cycles, a behavioural target, and a decoupled monitor.
module tb_cdi_bus_ctrl;

    localparam int ROM_WAIT = 2;
    localparam int IO_WAIT  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        as;
    logic        lds;
    logic        uds;
    logic        write_strobe;
    logic [23:1] addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        bus_ack;
    logic        bus_err;
    logic        mem_req;
    logic [1:0]  mem_sel;
    logic        mem_we;
    logic [1:0]  mem_be;
    logic [23:1] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    cdi_bus_ctrl #(
        .ROM_WAIT(ROM_WAIT),
        .IO_WAIT (IO_WAIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .as          (as),
        .lds         (lds),
        .uds         (uds),
        .write_strobe(write_strobe),
        .addr        (addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .bus_ack     (bus_ack),
        .bus_err     (bus_err),
        .mem_req     (mem_req),
        .mem_sel     (mem_sel),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    typedef struct {
        bit          is_err;
        logic [1:0]  sel;
        bit          we;
        logic [1:0]  be;
        logic [23:1] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          plan_delay[$];
    logic [15:0] plan_rdata[$];
    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          done_cnt  = 0;
    int          txn_cnt   = 0;
    logic [15:0] model_rdata = 16'h0000;
    logic        rst_q = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: region and wait counts straight from the address map.
    function automatic int region_wait(input logic [1:0] s);
        if (s == 2'd1) return ROM_WAIT;
        if (s == 2'd2) return IO_WAIT;
        return 0;
    endfunction

    function automatic int ack_to_done(input int w);
        if (w == 0) return 1;
        if (w < 2)  return 2;
        return w;
    endfunction

    task automatic arm(input logic [23:0] a, input bit we, input logic [1:0] be,
                       input logic [15:0] wd, input int delay, input logic [15:0] rd);
        exp_t e;
        e.is_err = 1'b0;
        e.sel    = 2'd0;
        if (a < 24'h100000)                           e.sel = 2'd0;
        else if (a >= 24'h180000 && a < 24'h200000)   e.sel = 2'd1;
        else if (a >= 24'h300000 && a < 24'h400000)   e.sel = 2'd2;
        else                                          e.is_err = 1'b1;
        e.we    = we;
        e.be    = be;
        e.addr  = a[23:1];
        e.wdata = wd;
        if (!e.is_err && !we) model_rdata = rd;
        e.rdata     = model_rdata;
        e.lat       = ack_to_done(region_wait(e.sel));
        e.start_cyc = cyc;
        if (!e.is_err) begin
            plan_delay.push_back(delay);
            plan_rdata.push_back(rd);
        end
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [23:0] a, input bit we, input logic [1:0] be, input logic [15:0] wd);
        as           = 1'b1;
        uds          = be[1];
        lds          = be[0];
        write_strobe = we;
        addr         = a[23:1];
        cpu_wdata    = wd;
    endtask

    task automatic release_strobes();
        as  = 1'b0;
        lds = 1'b0;
        uds = 1'b0;
    endtask

    task automatic flush();
        exp_q.delete();
        plan_delay.delete();
        plan_rdata.delete();
        model_rdata = 16'h0000;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        release_strobes();
        @(negedge clk); #1;
        flush();
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b0;
    endtask

    task automatic wait_done(input int start, input bit drop_early);
        int k;
        if (drop_early) begin
            @(posedge clk); #2;
            release_strobes();
        end
        k = 0;
        while (done_cnt == start && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt == start) begin
            check("done_timeout", 32'(done_cnt - start), 32'd1);
            do_reset();
        end else begin
            #2;
            release_strobes();
        end
    endtask

    task automatic run_txn(input logic [23:0] a, input bit we, input logic [1:0] be,
                           input logic [15:0] wd, input int delay, input logic [15:0] rd,
                           input bit drop_early);
        int start;
        @(posedge clk); #2;
        start = done_cnt;
        drive(a, we, be, wd);
        arm(a, we, be, wd, delay, rd);
        wait_done(start, drop_early);
    endtask

    // Target: acks after the planned number of request cycles; stray acks while idle must be ignored.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(posedge clk); #2;
            mem_ack   = 1'b0;
            mem_rdata = 16'($urandom);
            if (mem_req && !reset && plan_delay.size() > 0) begin
                if (plan_delay[0] == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = plan_rdata.pop_front();
                    void'(plan_delay.pop_front());
                end else begin
                    plan_delay[0] = plan_delay[0] - 1;
                end
            end else if (!mem_req && $urandom_range(0, 7) == 0) begin
                mem_ack = 1'b1;
            end
        end
    end

    // Monitor: compares every DUT response against the head of the expectation queue.
    initial begin
        exp_t e;
        bit   req_seen;
        bit   ack_prev;
        int   ack_cyc;
        req_seen = 1'b0;
        ack_prev = 1'b0;
        ack_cyc  = 0;
        forever begin
            @(negedge clk);
            if (rst_q) begin
                check("rst_ctrl_outputs", 32'({mem_req, bus_ack, bus_err, mem_we, mem_sel, mem_be}), 32'd0);
                check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
                check("rst_mem_addr", 32'(mem_addr), 32'd0);
                check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
                req_seen = 1'b0;
                ack_prev = 1'b0;
            end else if (!reset) begin
                if (ack_prev) check("req_drop_after_ack", 32'(mem_req), 32'd0);
                ack_prev = mem_req && mem_ack;
                if (mem_req && !req_seen) begin
                    req_seen = 1'b1;
                    if (exp_q.size() == 0) begin
                        check("req_unexpected", 32'(mem_req), 32'd0);
                    end else begin
                        e = exp_q[0];
                        check("req_for_mapped", 32'(e.is_err), 32'd0);
                        check("req_latency", 32'(cyc - e.start_cyc), 32'd1);
                        check("mem_sel", 32'(mem_sel), 32'(e.sel));
                        check("mem_we", 32'(mem_we), 32'(e.we));
                        check("mem_be", 32'(mem_be), 32'(e.be));
                        check("mem_addr", 32'(mem_addr), 32'(e.addr));
                        check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
                    end
                end
                if (mem_req && mem_ack) ack_cyc = cyc;
                if (bus_ack || bus_err) begin
                    check("ack_err_exclusive", 32'(bus_ack && bus_err), 32'd0);
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        check("done_unexpected", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        txn_cnt++;
                        if (bus_ack) begin
                            check("ack_kind", 32'(e.is_err), 32'd0);
                            check("ack_latency", 32'(cyc - ack_cyc), 32'(e.lat));
                            check("cpu_rdata", 32'(cpu_rdata), 32'(e.rdata));
                            check("ack_had_req", 32'(req_seen), 32'd1);
                        end else begin
                            check("err_kind", 32'(e.is_err), 32'd1);
                            check("err_latency", 32'(cyc - e.start_cyc), 32'd2);
                            check("err_no_req", 32'(req_seen), 32'd0);
                        end
                        $display("txn %0d: %s addr=0x%06h we=%0d be=%0d sel=%0d rdata=0x%04h cycle=%0d",
                                 txn_cnt, bus_ack ? "ack" : "err", {e.addr, 1'b0}, e.we, e.be,
                                 e.sel, cpu_rdata, cyc);
                    end
                    req_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        logic [23:0] a;
        int          k;
        int          start;

        reset        = 1'b1;
        as           = 1'b0;
        lds          = 1'b0;
        uds          = 1'b0;
        write_strobe = 1'b0;
        addr         = '0;
        cpu_wdata    = 16'h0000;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;

        // Directed cases from the address map and wait-state rules.
        run_txn(24'h000100, 1'b0, 2'b11, 16'h0000, 0, 16'hBEEF, 1'b0);
        run_txn(24'h180000, 1'b0, 2'b11, 16'h0000, 2, 16'h4AFC, 1'b0);
        run_txn(24'h300001, 1'b1, 2'b01, 16'h005A, 1, 16'h1234, 1'b0);
        run_txn(24'h500000, 1'b0, 2'b11, 16'h0000, 0, 16'h0000, 1'b0);
        run_txn(24'h0FFFFE, 1'b1, 2'b10, 16'hA5A5, 3, 16'h7777, 1'b1);
        run_txn(24'h1FFFFE, 1'b0, 2'b11, 16'h0000, 0, 16'hC0DE, 1'b1);
        run_txn(24'h100000, 1'b1, 2'b01, 16'h0011, 0, 16'h0000, 1'b1);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: a = 24'($urandom_range(0, 32'h0FFFFF));
                1: a = 24'h180000 + 24'($urandom_range(0, 32'h07FFFF));
                2: a = 24'h300000 + 24'($urandom_range(0, 32'h0FFFFF));
                default: begin
                    case ($urandom_range(0, 2))
                        0:       a = 24'h100000 + 24'($urandom_range(0, 32'h07FFFF));
                        1:       a = 24'h200000 + 24'($urandom_range(0, 32'h0FFFFF));
                        default: a = 24'h400000 + 24'($urandom_range(0, 32'hBFFFFF));
                    endcase
                end
            endcase
            run_txn(a, 1'($urandom_range(0, 1)), 2'($urandom_range(1, 3)), 16'($urandom),
                    $urandom_range(0, 4), 16'($urandom), 1'($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Address strobe without any data strobe must not start a cycle.
        @(posedge clk); #2;
        as           = 1'b1;
        lds          = 1'b0;
        uds          = 1'b0;
        addr         = 23'h000080;
        repeat (3) begin
            @(negedge clk);
            check("as_only_no_req", 32'(mem_req), 32'd0);
        end
        @(posedge clk); #2;
        release_strobes();

        // Hung RAM read: request persists, then reset with strobes held through release.
        @(posedge clk); #2;
        start = done_cnt;
        drive(24'h000100, 1'b0, 2'b11, 16'h0000);
        arm(24'h000100, 1'b0, 2'b11, 16'h0000, 1000, 16'h0000);
        k = 0;
        while (!mem_req && k < 10) begin
            @(posedge clk); #2;
            k++;
        end
        check("hung_req_up", 32'(mem_req), 32'd1);
        repeat (20) @(posedge clk);
        #2;
        check("hung_req_held", 32'(mem_req), 32'd1);
        check("hung_no_done", 32'(done_cnt - start), 32'd0);
        reset = 1'b1;
        @(negedge clk); #1;
        flush();
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b0;
        start = done_cnt;
        arm(24'h000100, 1'b0, 2'b11, 16'h0000, 0, 16'hBEEF);
        wait_done(start, 1'b0);

        repeat (4) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
